gf_mult_state: RTL and testbench

Iterative GF(2^8) lane multiplier for the AES datapath. It multiplies each byte of a NUM_BYTES-wide state by its own 8-bit coefficient modulo a programmable reduction polynomial. It generalises the fixed doubling stage to arbitrary coefficients such as {02}, {03}, {09}, {0B}, {0D} and {0E}, covering both forward and inverse MixColumns. It uses a valid/ready handshake on both sides and a configurable number of coefficient bits per cycle, trading latency against area.

---
 rtl/gf_mult_state.sv | 117 +++++++++++
 tb/tb_gf_mult_state.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult_state.sv
`default_nettype none
// ============================================================================
// Module   : gf_mult_state
// Brief    : Iterative per-lane GF(2^8) multiplier, Horner MSB-first, valid/ready.
// Revision : 1.0
// ============================================================================
module gf_mult_state #(
  parameter int         NUM_BYTES      = 16,
  parameter logic [7:0] POLY           = 8'h1B,
  parameter int         BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic [8*NUM_BYTES-1:0] coeff_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   busy
);

  localparam int STEPS = 8 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
      $error("gf_mult_state: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [8*NUM_BYTES-1:0]   r_a;
  logic [8*NUM_BYTES-1:0]   r_b;
  logic [8*NUM_BYTES-1:0]   r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [8*NUM_BYTES-1:0]   w_acc_nxt;
  logic [8*NUM_BYTES-1:0]   w_b_nxt;
  logic                     w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  // One cycle of work: BITS_PER_CYCLE cascaded Horner steps, returns {acc, b}.
  function automatic logic [15:0] lane_step(input logic [7:0] acc_in,
                                            input logic [7:0] a,
                                            input logic [7:0] b_in);
    logic [7:0] acc;
    logic [7:0] b;
    acc = acc_in;
    b   = b_in;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      acc = xtime(acc) ^ (b[7] ? a : 8'h00);
      b   = {b[6:0], 1'b0};
    end
    return {acc, b};
  endfunction

  generate
    for (genvar l = 0; l < NUM_BYTES; l++) begin : g_lane
      assign {w_acc_nxt[8*l +: 8], w_b_nxt[8*l +: 8]} =
        lane_step(r_acc[8*l +: 8], r_a[8*l +: 8], r_b[8*l +: 8]);
    end
  endgenerate

  assign in_ready  = !rst && ((r_state == S_IDLE) ||
                              ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC);
  assign data_out  = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a     <= data_in;
            r_b     <= coeff_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf_mult_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_mult_state
// Brief    : Self-checking bench for gf_mult_state across lane widths and polys.
// Revision : 1.0
// ============================================================================
module tb_gf_mult_state;

  localparam int NB = 16;
  localparam int W  = 8 * NB;
  localparam int ND = 5;

  function automatic int bpc_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] poly_of(input int i);
    return (i == 4) ? 8'h1D : 8'h1B;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [ND];
  logic         ordy [ND];
  logic         ir   [ND];
  logic         ov   [ND];
  logic         bs   [ND];
  logic [W-1:0] din  [ND];
  logic [W-1:0] cin  [ND];
  logic [W-1:0] dout [ND];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      gf_mult_state #(
        .NUM_BYTES(NB), .POLY(poly_of(g)), .BITS_PER_CYCLE(bpc_of(g))
      ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(iv[g]), .in_ready(ir[g]),
        .data_in(din[g]), .coeff_in(cin[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]),
        .data_out(dout[g]), .busy(bs[g])
      );
    end
  endgenerate

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: shift-and-add over coefficient bits LSB-first.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] poly);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ poly) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gvec(input logic [W-1:0] a, input logic [W-1:0] c,
                                        input logic [7:0] poly);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = gmul(a[8*i +: 8], c[8*i +: 8], poly);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready high; checks busy, latency and release.
  task automatic run_txn(input int d, input logic [W-1:0] a, input logic [W-1:0] c,
                         output logic [W-1:0] res);
    int n;
    din[d] = a; cin[d] = c; iv[d] = 1'b1; ordy[d] = 1'b1;
    n = 0;
    while (!ir[d] && n < 50) begin tick(); n++; end
    chk($sformatf("in_ready_d%0d", d), W'(ir[d]), W'(1));
    tick();
    iv[d] = 1'b0; din[d] = rnd_vec(); cin[d] = rnd_vec();
    chk($sformatf("busy_d%0d", d), W'(bs[d]), W'(1));
    n = 0;
    while (!ov[d] && n < 40) begin tick(); n++; end
    chk($sformatf("latency_d%0d", d), W'(n), W'(8 / bpc_of(d)));
    res = dout[d];
    tick();
    chk($sformatf("released_d%0d", d), W'(ov[d]), W'(0));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [W-1:0] a_v, c_v, e_v, r_v, hold;
  logic [W-1:0] exp_q [$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, got, last, cyc;
    tbl[0] = '{8'h80, 8'h02, 8'h1B};
    tbl[1] = '{8'hD4, 8'h02, 8'hB3};
    tbl[2] = '{8'hBF, 8'h03, 8'hDA};
    tbl[3] = '{8'h57, 8'h01, 8'h57};
    tbl[4] = '{8'h57, 8'h00, 8'h00};
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0; cin[d] = '0;
    end

    // Reset behaviour
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("rst_in_ready_d%0d", d), W'(ir[d]), W'(0));
    rst = 1'b0;
    tick();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("post_rst_in_ready_d%0d", d), W'(ir[d]), W'(1));
      chk($sformatf("post_rst_out_valid_d%0d", d), W'(ov[d]), W'(0));
      chk($sformatf("post_rst_busy_d%0d", d), W'(bs[d]), W'(0));
      chk($sformatf("post_rst_data_out_d%0d", d), dout[d], W'(0));
    end

    // FIPS-197 products
    run_txn(0, {NB{8'h57}}, {NB{8'h83}}, r_v);
    chk("fips_57x83", r_v, {NB{8'hC1}});
    run_txn(0, {NB{8'h57}}, {NB{8'h13}}, r_v);
    chk("fips_57x13", r_v, {NB{8'hFE}});

    // Table lanes 0..4, remaining lanes random, every step width
    for (int d = 0; d < 4; d++) begin
      for (int rep = 0; rep < 20; rep++) begin
        a_v = rnd_vec(); c_v = rnd_vec();
        if (rep == 0) for (int i = 0; i < 5; i++) begin
          a_v[8*i +: 8] = tbl[i].a; c_v[8*i +: 8] = tbl[i].c;
        end
        e_v = gvec(a_v, c_v, 8'h1B);
        if (rep == 0) for (int i = 0; i < 5; i++) e_v[8*i +: 8] = tbl[i].exp;
        run_txn(d, a_v, c_v, r_v);
        chk($sformatf("table_d%0d_rep%0d", d, rep), r_v, e_v);
      end
    end

    // Backpressure with a competing in_valid held high
    a_v = rnd_vec(); c_v = rnd_vec();
    din[0] = a_v; cin[0] = c_v; ordy[0] = 1'b0; iv[0] = 1'b1;
    tick();
    din[0] = rnd_vec(); cin[0] = rnd_vec();
    n = 0;
    while (!ov[0] && n < 40) begin tick(); n++; end
    hold = dout[0];
    chk("bp_result", hold, gvec(a_v, c_v, 8'h1B));
    for (int k = 0; k < 20; k++) begin
      din[0] = rnd_vec(); cin[0] = rnd_vec();
      tick();
      chk("bp_data_stable", dout[0], hold);
      chk("bp_in_ready_low", W'(ir[0]), W'(0));
      chk("bp_out_valid_held", W'(ov[0]), W'(1));
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    chk("bp_in_ready_on_out_ready", W'(ir[0]), W'(1));
    tick();
    chk("bp_consumed", W'(ov[0]), W'(0));
    chk("bp_back_to_idle", W'(bs[0]), W'(0));

    // Pass-through accept, BITS_PER_CYCLE=2
    ordy[1] = 1'b1; iv[1] = 1'b1;
    got = 0; last = -1; cyc = 0;
    while (got < 5 && cyc < 200) begin
      din[1] = rnd_vec(); cin[1] = rnd_vec();
      #0;
      if (ir[1] && iv[1]) exp_q.push_back(gvec(din[1], cin[1], 8'h1B));
      if (ov[1]) begin
        chk($sformatf("pt_result_%0d", got), dout[1], exp_q[0]);
        void'(exp_q.pop_front());
        chk($sformatf("pt_same_cycle_accept_%0d", got), W'(ir[1]), W'(1));
        if (last >= 0) chk($sformatf("pt_spacing_%0d", got), W'(cyc - last), W'(5));
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    chk("pt_count", W'(got), W'(5));
    iv[1] = 1'b0;
    n = 0;
    while (!ov[1] && n < 40) begin tick(); n++; end
    if (exp_q.size() > 0) chk("pt_drain", dout[1], exp_q[0]);
    tick();
    exp_q.delete();

    // Reset during CALC step 3
    din[0] = {NB{8'h57}}; cin[0] = {NB{8'h83}}; iv[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", W'(ov[0]), W'(0));
    chk("rst_mid_data_out", dout[0], W'(0));
    chk("rst_mid_busy", W'(bs[0]), W'(0));
    chk("rst_mid_in_ready", W'(ir[0]), W'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", W'(ir[0]), W'(1));
    run_txn(0, {NB{8'h57}}, {NB{8'h83}}, r_v);
    chk("rst_recover_57x83", r_v, {NB{8'hC1}});

    // Alternate polynomial 0x11D
    a_v = rnd_vec(); c_v = rnd_vec();
    a_v[7:0] = 8'h80; c_v[7:0] = 8'h02;
    e_v = gvec(a_v, c_v, 8'h1D);
    e_v[7:0] = 8'h1D;
    run_txn(4, a_v, c_v, r_v);
    chk("poly1d_80x02", r_v, e_v);
    for (int k = 0; k < 2000; k++) begin
      a_v = rnd_vec(); c_v = rnd_vec();
      run_txn(4, a_v, c_v, r_v);
      chk($sformatf("poly1d_rand_%0d", k), r_v, gvec(a_v, c_v, 8'h1D));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
